multicycle_ctrl: RTL

- Multi-cycle RV32I control unit; next generation of the single-cycle decoder.
- Latches each fetched instruction and steps an FSM through FETCH/DECODE/EXEC/MEM/WB, driving datapath controls per state.
- Uses handshakes to instruction and data memory, detects illegal opcodes and memory timeouts, and pulses one retire per instruction.
- Sits between the PC/IR registers, the register file, ALU, immediate extender, and data memory.

---
 rtl/multicycle_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I control unit.
// Latches the fetched instruction and steps it through FETCH/DECODE/EXEC/MEM/WB,
// with ready handshakes to both memories, illegal-opcode and timeout traps, and
// a single retire pulse per completed instruction.
module multicycle_ctrl #(
    parameter int ALUOP_W    = 5,
    parameter int EXTOP_W    = 6,
    parameter int WAIT_LIMIT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instr,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    input  logic               Zero,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic [1:0]         PCSrc,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic [1:0]         ALUSrcA,
    output logic               ALUSrc,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [EXTOP_W-1:0] EXTOp,
    output logic [1:0]         WDSrc,
    output logic [2:0]         DMType,
    output logic               retire,
    output logic               trap,
    output logic [1:0]         trap_cause
);

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC, MEM_ADDR, MEM_RD, MEM_WR, WB, BRANCH, JUMP, TRAP
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SRL  = 4'd3;
    localparam logic [3:0] ALU_SRA  = 4'd4;
    localparam logic [3:0] ALU_AND  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_XOR  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [5:0] EXT_SHAMT = 6'b100000;
    localparam logic [5:0] EXT_I     = 6'b010000;
    localparam logic [5:0] EXT_S     = 6'b001000;
    localparam logic [5:0] EXT_B     = 6'b000100;
    localparam logic [5:0] EXT_U     = 6'b000010;
    localparam logic [5:0] EXT_J     = 6'b000001;

    // Counter value at which one more stalled cycle reaches the limit.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [7:0]  wait_q, wait_d;
    logic [1:0]  cause_q, cause_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       rd_nz;
    logic       unused_ir_bits;

    logic       is_rtype, is_ialu, is_lui, is_auipc, is_load, is_store;
    logic       is_branch, is_jal, is_jalr;
    logic [3:0] alu_fn;
    logic [3:0] br_op;
    logic       br_taken;
    logic [2:0] dm_type;

    logic [1:0] ex_src_a;
    logic       ex_src;
    logic [3:0] ex_op;
    logic [5:0] ex_ext;

    logic       imem_req_c, dmem_req_c, ir_write_c, pc_write_c;
    logic [1:0] pc_src_c;
    logic       reg_write_c, mem_write_c;
    logic [1:0] alu_src_a_c;
    logic       alu_src_c;
    logic [3:0] alu_op_c;
    logic [5:0] ext_op_c;
    logic [1:0] wd_src_c;
    logic [2:0] dm_type_c;
    logic       retire_c;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign funct7 = ir_q[31:25];
    assign rd_nz  = (ir_q[11:7] != 5'd0);

    // Register-source and immediate fields are consumed by the datapath, not here.
    assign unused_ir_bits = ^ir_q[24:15];

    // Classify the latched instruction; only fully legal encodings set a class flag.
    always_comb begin
        is_rtype  = 1'b0;
        is_ialu   = 1'b0;
        is_lui    = 1'b0;
        is_auipc  = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        case (opcode)
            OP_R: is_rtype = (funct7 == 7'b0000000) ||
                             (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
            OP_I: begin
                case (funct3)
                    3'b001:  is_ialu = (funct7 == 7'b0000000);
                    3'b101:  is_ialu = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    default: is_ialu = 1'b1;
                endcase
            end
            OP_LUI:    is_lui    = 1'b1;
            OP_AUIPC:  is_auipc  = 1'b1;
            OP_LOAD:   is_load   = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                                   (funct3 == 3'b100) || (funct3 == 3'b101);
            OP_STORE:  is_store  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
            OP_BRANCH: is_branch = (funct3 != 3'b010) && (funct3 != 3'b011);
            OP_JAL:    is_jal    = 1'b1;
            OP_JALR:   is_jalr   = (funct3 == 3'b000);
            default:   ;
        endcase
    end

    // Map funct3/funct7 to ALU operation, branch compare, and memory access width.
    always_comb begin
        alu_fn = ALU_ADD;
        case (funct3)
            3'b000:  alu_fn = (is_rtype && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_fn = ALU_SLL;
            3'b010:  alu_fn = ALU_SLT;
            3'b011:  alu_fn = ALU_SLTU;
            3'b100:  alu_fn = ALU_XOR;
            3'b101:  alu_fn = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  alu_fn = ALU_OR;
            default: alu_fn = ALU_AND;
        endcase

        br_op    = ALU_SUB;
        br_taken = Zero ^ funct3[0];
        if (funct3[2]) begin
            br_op    = funct3[1] ? ALU_SLTU : ALU_SLT;
            br_taken = ~Zero ^ funct3[0];
        end

        dm_type = 3'b000;
        case (funct3)
            3'b000:  dm_type = 3'b011;
            3'b001:  dm_type = 3'b001;
            3'b100:  dm_type = 3'b100;
            3'b101:  dm_type = 3'b010;
            default: dm_type = 3'b000;
        endcase
    end

    // ALU operand/operation selection for register-writing ALU instructions.
    always_comb begin
        ex_src_a = 2'b00;
        ex_src   = 1'b0;
        ex_op    = alu_fn;
        ex_ext   = 6'b000000;
        if (is_ialu) begin
            ex_src = 1'b1;
            ex_ext = (funct3 == 3'b001 || funct3 == 3'b101) ? EXT_SHAMT : EXT_I;
        end else if (is_lui) begin
            ex_src_a = 2'b10;
            ex_src   = 1'b1;
            ex_op    = ALU_ADD;
            ex_ext   = EXT_U;
        end else if (is_auipc) begin
            ex_src_a = 2'b01;
            ex_src   = 1'b1;
            ex_op    = ALU_ADD;
            ex_ext   = EXT_U;
        end
    end

    // Next-state, wait-counter and datapath strobes for the current state.
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        wait_d      = 8'd0;
        cause_d     = cause_q;
        imem_req_c  = 1'b0;
        dmem_req_c  = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        pc_src_c    = 2'b00;
        reg_write_c = 1'b0;
        mem_write_c = 1'b0;
        alu_src_a_c = 2'b00;
        alu_src_c   = 1'b0;
        alu_op_c    = ALU_ADD;
        ext_op_c    = 6'b000000;
        wd_src_c    = 2'b00;
        dm_type_c   = 3'b000;
        retire_c    = 1'b0;

        case (state_q)
            FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ready) begin
                    ir_write_c = 1'b1;
                    ir_d       = instr;
                    state_d    = DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = TRAP;
                    cause_d = 2'b10;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            DECODE: begin
                if (is_rtype || is_ialu || is_lui || is_auipc) begin
                    state_d = EXEC;
                end else if (is_load || is_store) begin
                    state_d = MEM_ADDR;
                end else if (is_branch) begin
                    state_d = BRANCH;
                end else if (is_jal || is_jalr) begin
                    state_d = JUMP;
                end else begin
                    state_d = TRAP;
                    cause_d = 2'b01;
                end
            end
            EXEC: begin
                alu_src_a_c = ex_src_a;
                alu_src_c   = ex_src;
                alu_op_c    = ex_op;
                ext_op_c    = ex_ext;
                state_d     = WB;
            end
            MEM_ADDR, MEM_RD, MEM_WR: begin
                // The address stays on the ALU for the whole memory access.
                alu_src_c = 1'b1;
                alu_op_c  = ALU_ADD;
                ext_op_c  = is_store ? EXT_S : EXT_I;
                if (state_q == MEM_ADDR) begin
                    state_d = is_store ? MEM_WR : MEM_RD;
                end else begin
                    dmem_req_c  = 1'b1;
                    mem_write_c = (state_q == MEM_WR);
                    dm_type_c   = dm_type;
                    if (dmem_ready) begin
                        if (state_q == MEM_WR) begin
                            pc_write_c = 1'b1;
                            retire_c   = 1'b1;
                            state_d    = FETCH;
                        end else begin
                            state_d = WB;
                        end
                    end else if (wait_q == WAIT_LAST) begin
                        state_d = TRAP;
                        cause_d = 2'b11;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
            end
            WB: begin
                if (is_load) begin
                    wd_src_c = 2'b01;
                end else begin
                    alu_src_a_c = ex_src_a;
                    alu_src_c   = ex_src;
                    alu_op_c    = ex_op;
                    ext_op_c    = ex_ext;
                end
                reg_write_c = rd_nz;
                pc_write_c  = 1'b1;
                retire_c    = 1'b1;
                state_d     = FETCH;
            end
            BRANCH: begin
                alu_op_c   = br_op;
                ext_op_c   = EXT_B;
                pc_src_c   = br_taken ? 2'b01 : 2'b00;
                pc_write_c = 1'b1;
                retire_c   = 1'b1;
                state_d    = FETCH;
            end
            JUMP: begin
                reg_write_c = rd_nz;
                wd_src_c    = 2'b10;
                pc_write_c  = 1'b1;
                retire_c    = 1'b1;
                if (is_jalr) begin
                    alu_src_c = 1'b1;
                    ext_op_c  = EXT_I;
                    pc_src_c  = 2'b10;
                end else begin
                    ext_op_c  = EXT_J;
                    pc_src_c  = 2'b01;
                end
                state_d = FETCH;
            end
            TRAP: state_d = TRAP;
            default: state_d = FETCH;
        endcase
    end

    // State, instruction latch, wait counter and trap cause registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            ir_q    <= 32'd0;
            wait_q  <= 8'd0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            wait_q  <= wait_d;
            cause_q <= cause_d;
        end
    end

    // While reset is held, every strobe except the fetch request is forced low.
    assign imem_req   = imem_req_c;
    assign dmem_req   = dmem_req_c  & ~rst;
    assign IRWrite    = ir_write_c  & ~rst;
    assign PCWrite    = pc_write_c  & ~rst;
    assign PCSrc      = rst ? 2'b00 : pc_src_c;
    assign RegWrite   = reg_write_c & ~rst;
    assign MemWrite   = mem_write_c & ~rst;
    assign ALUSrcA    = rst ? 2'b00 : alu_src_a_c;
    assign ALUSrc     = alu_src_c   & ~rst;
    assign ALUOp      = rst ? '0 : ALUOP_W'(alu_op_c);
    assign EXTOp      = rst ? '0 : EXTOP_W'(ext_op_c);
    assign WDSrc      = rst ? 2'b00 : wd_src_c;
    assign DMType     = rst ? 3'b000 : dm_type_c;
    assign retire     = retire_c    & ~rst;
    assign trap       = (state_q == TRAP) & ~rst;
    assign trap_cause = rst ? 2'b00 : cause_q;

endmodule
